// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: per-channel byte FIFOs arbitrated onto one uart_tx input,
// with each issued byte followed by a full frame time of silence.
module uart_tx_arbiter #(
    parameter int N_CH         = 2,
    parameter int DATA_WIDTH   = 8,
    parameter int FIFO_DEPTH   = 16,
    parameter int FRAME_CYCLES = 52083
) (
    input  logic                       i_clk_sys,
    input  logic                       i_rst_n,
    input  logic [N_CH*DATA_WIDTH-1:0] i_ch_data,
    input  logic [N_CH-1:0]            i_ch_valid,
    input  logic                       i_mode,
    input  logic                       i_clr_ovf,
    output logic [N_CH-1:0]            o_ch_full,
    output logic [N_CH-1:0]            o_ch_ovf,
    output logic [DATA_WIDTH-1:0]      o_tx_data,
    output logic                       o_tx_valid,
    output logic [N_CH-1:0]            o_grant,
    output logic                       o_busy
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int RW = N_CH > 1 ? $clog2(N_CH) : 1;
    localparam int TW = $clog2(FRAME_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, LOAD, HOLD} state_t;

    state_t                state_q, state_d;
    logic [TW-1:0]         cnt_q, cnt_d;
    logic [RW-1:0]         rr_q, rr_d;
    logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d;
    logic                  tx_valid_q, tx_valid_d;
    logic [N_CH-1:0]       grant_q, grant_d;
    logic [N_CH-1:0]       full_q, full_d, ovf_q, ovf_d;
    logic [CW-1:0]         wr_q [N_CH];
    logic [CW-1:0]         wr_d [N_CH];
    logic [CW-1:0]         rd_q [N_CH];
    logic [CW-1:0]         rd_d [N_CH];
    logic [CW-1:0]         count_q [N_CH];
    logic [CW-1:0]         count_d [N_CH];
    logic [DATA_WIDTH-1:0] mem_q [N_CH][FIFO_DEPTH];
    logic [N_CH-1:0]       nonempty, push, pop;
    logic [RW-1:0]         sel, idx;
    logic                  found;

    always_comb begin
        for (int k = 0; k < N_CH; k++) nonempty[k] = wr_q[k] != rd_q[k];
    end

    // Mode 1 searches upward from the channel after the last grant.
    always_comb begin
        sel = '0;
        idx = '0;
        found = 1'b0;
        for (int i = 0; i < N_CH; i++) begin
            idx = i_mode ? RW'((int'(rr_q) + 1 + i) % N_CH) : RW'(i);
            if (!found && nonempty[idx]) begin
                sel = idx;
                found = 1'b1;
            end
        end
    end

    always_comb begin
        pop = '0;
        state_d = state_q;
        cnt_d = cnt_q;
        rr_d = rr_q;
        tx_data_d = tx_data_q;
        tx_valid_d = 1'b0;
        grant_d = grant_q;
        case (state_q)
            IDLE: if (found) begin
                pop[sel] = 1'b1;
                tx_data_d = mem_q[sel][rd_q[sel][AW-1:0]];
                grant_d = N_CH'(1) << sel;
                rr_d = sel;
                tx_valid_d = 1'b1;
                state_d = LOAD;
            end
            LOAD: begin
                cnt_d = TW'(FRAME_CYCLES - 1);
                state_d = HOLD;
            end
            HOLD: begin
                cnt_d = cnt_q == '0 ? '0 : cnt_q - 1'b1;
                state_d = cnt_q == '0 ? IDLE : HOLD;
            end
            default: state_d = IDLE;
        endcase
    end

    // A push into a full FIFO is dropped even when that FIFO pops this cycle.
    always_comb begin
        for (int k = 0; k < N_CH; k++) begin
            push[k] = i_ch_valid[k] && count_q[k] != CW'(FIFO_DEPTH);
            wr_d[k] = wr_q[k] + CW'(push[k]);
            rd_d[k] = rd_q[k] + CW'(pop[k]);
            count_d[k] = count_q[k] + CW'(push[k]) - CW'(pop[k]);
            full_d[k] = count_d[k] == CW'(FIFO_DEPTH);
            ovf_d[k] = (i_ch_valid[k] && !push[k]) || (ovf_q[k] && !i_clr_ovf);
        end
    end

    always_ff @(posedge i_clk_sys or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            cnt_q <= '0;
            rr_q <= RW'(N_CH - 1);
            tx_data_q <= '0;
            tx_valid_q <= 1'b0;
            grant_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            rr_q <= rr_d;
            tx_data_q <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            grant_q <= grant_d;
        end
    end

    always_ff @(posedge i_clk_sys or negedge i_rst_n) begin
        if (!i_rst_n) begin
            full_q <= '0;
            ovf_q <= '0;
            for (int k = 0; k < N_CH; k++) begin
                wr_q[k] <= '0;
                rd_q[k] <= '0;
                count_q[k] <= '0;
            end
        end else begin
            full_q <= full_d;
            ovf_q <= ovf_d;
            for (int k = 0; k < N_CH; k++) begin
                wr_q[k] <= wr_d[k];
                rd_q[k] <= rd_d[k];
                count_q[k] <= count_d[k];
            end
        end
    end

    always_ff @(posedge i_clk_sys) begin
        for (int k = 0; k < N_CH; k++)
            if (push[k]) mem_q[k][wr_q[k][AW-1:0]] <= i_ch_data[k*DATA_WIDTH +: DATA_WIDTH];
    end

    assign o_ch_full = full_q;
    assign o_ch_ovf = ovf_q;
    assign o_tx_data = tx_data_q;
    assign o_tx_valid = tx_valid_q;
    assign o_grant = grant_q;
    assign o_busy = (|nonempty) || state_q != IDLE;
endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Parametrised N-channel UART transmit arbiter with a per-channel byte FIFO.
- Replaces the hard-wired two-source select between the checksum/ack path and the state-machine reply path in front of uart_tx.
- Sits between the byte producers (rcv check codes, state replies, future status/debug sources) and uart_tx.
- Emits one i_data_valid pulse per byte and self-paces the pulses to the UART frame time, so no byte is lost while uart_tx is shifting.

Parameters:
- N_CH, 2, number of producer channels (1..8).
- DATA_WIDTH, 8, byte width.
- FIFO_DEPTH, 16, entries per channel FIFO; power of two, at least 2.
- FRAME_CYCLES, 52083, clocks reserved per transmitted frame. Default is 50 MHz / 9600 baud × 10 bits, rounded down.

Ports:
- i_clk_sys  in  1  system clock (50 MHz).
- i_rst_n  in  1  asynchronous active-low reset.
- i_ch_data  in  N_CH*DATA_WIDTH  channel k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
- i_ch_valid  in  N_CH  1-cycle push strobe per channel.
- i_mode  in  1  0 = fixed priority (ch0 highest), 1 = round robin.
- i_clr_ovf  in  1  clears all sticky overflow flags.
- o_ch_full  out  N_CH  FIFO k full.
- o_ch_ovf  out  N_CH  sticky: a push to FIFO k was dropped.
- o_tx_data  out  DATA_WIDTH  byte to uart_tx i_data_tx.
- o_tx_valid  out  1  1-cycle strobe to uart_tx i_data_valid.
- o_grant  out  N_CH  one-hot channel of the last issued byte.
- o_busy  out  1  high when any FIFO is non-empty or the FSM is not in IDLE.

Behaviour:
- Clock and reset:
  - One clock, i_clk_sys.
  - Reset is asynchronous and active-low on i_rst_n.
  - On reset: all FIFOs empty, state IDLE, spacing counter 0, round-robin pointer = N_CH-1 (so ch0 is searched first).
  - On reset every output is 0: o_tx_data, o_tx_valid, o_grant, o_ch_ovf, o_ch_full, o_busy.
  - Reset mid-frame discards all queued bytes and any pending pacing.
- FIFO per channel:
  - Write pointer, read pointer and count are registered; width is clog2(FIFO_DEPTH)+1.
  - A push with count == FIFO_DEPTH is dropped and sets o_ch_ovf[k]. This holds even if a pop occurs in the same cycle.
  - The set takes priority over i_clr_ovf in the same cycle.
  - o_ch_full[k] is (count == FIFO_DEPTH), registered.
  - Pointers wrap modulo FIFO_DEPTH.
- FSM:
  - IDLE: if any FIFO count is greater than 0, select a channel, pop one entry into o_tx_data, set o_grant, go to LOAD. Otherwise stay in IDLE.
  - LOAD: o_tx_valid = 1 for exactly this cycle; load the spacing counter with FRAME_CYCLES-1; go to HOLD.
  - HOLD: decrement the counter; at 0 go to IDLE.
  - o_tx_data and o_grant hold their values until the next pop.
- Selection:
  - Mode 0: lowest-index non-empty channel wins.
  - Mode 1: first non-empty channel searching from (last grant + 1) mod N_CH upward; the pointer updates on each pop.
  - i_mode is sampled only in IDLE, so a change takes effect at the next arbitration.
- Timing:
  - A push sampled at edge t into an empty FIFO with the FSM idle gives o_tx_valid high in cycle t+2.
  - With a continuous backlog, o_tx_valid pulses are spaced FRAME_CYCLES+2 cycles apart (HOLD = FRAME_CYCLES cycles, plus IDLE and LOAD).
- Simultaneous events:
  - A push and a pop on the same channel in one cycle are both performed, and the count is unchanged.
  - Pushes on several channels in the same cycle are all accepted independently.
- Byte order within a channel is strictly FIFO. Channels never starve in mode 1.

Test Plan (FRAME_CYCLES = 8, N_CH = 2, FIFO_DEPTH = 4):
- Reset, push 0xA5 on ch0 at edge t -> o_tx_valid = 1 with o_tx_data = 0xA5 and o_grant = 01 in cycle t+2 only. o_busy falls after HOLD ends.
- Mode 0: push 0x11, 0x12 on ch0 and 0x21 on ch1 in one burst -> output order 0x11, 0x12, 0x21, with valid pulses exactly 10 cycles apart.
- Mode 1: ch0 holds {0x11, 0x12} and ch1 holds {0x21, 0x22} -> output order 0x11, 0x21, 0x12, 0x22.
- Overflow:
  - Push 6 bytes into ch1 while HOLD is active -> first 4 are kept, o_ch_full[1] = 1, o_ch_ovf[1] = 1.
  - Pulse i_clr_ovf -> o_ch_ovf = 00; the kept 4 bytes still drain in order.
- Push on ch0 in the same cycle its FIFO pops with count 2 -> count stays 2 and no byte is lost or duplicated.
- Assert i_rst_n = 0 mid-HOLD with 3 bytes queued -> all outputs 0 immediately. After release, no o_tx_valid until a new push.
